// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: walks one shared Neuron over every neuron of a layer.
// Optional macro NEURON_SEQ_TIMEOUT_EN adds a WAIT watchdog and a sticky err flag.
module neuron_layer_sequencer #(
   parameter int NUM_NEURONS = 8,
   parameter int NUM_INPUTS  = 9,
   parameter int IN_W        = 9,
   parameter int TIMEOUT     = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start_,
   input  logic [NUM_INPUTS*IN_W-1:0]       inputs,
   output logic                             busy,
   output logic                             end_,
   output logic [NUM_NEURONS-1:0]           outs,
   output logic                             err,
   output logic                             n_start_,
   output logic [$clog2(NUM_NEURONS)-1:0]   n_sel,
   output logic [NUM_INPUTS*IN_W-1:0]       n_inputs,
   input  logic                             n_out,
   input  logic                             n_end_
);

   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam int VEC_W = NUM_INPUTS * IN_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

   if (NUM_NEURONS < 2 || TIMEOUT < 1) begin : g_param_check
      $error("neuron_layer_sequencer: NUM_NEURONS >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [NUM_NEURONS-1:0] outs_q;
   logic [VEC_W-1:0]   inputs_q;
   logic               hit;
   logic               res;
   logic               accept;

   assign accept = (state_q == S_IDLE) && start_;

`ifdef NEURON_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             expire;

   assign expire = (state_q == S_WAIT) && !n_end_ &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));
   assign hit    = n_end_ || expire;
   assign res    = n_end_ & n_out;
   assign err    = err_q;

   // Count consecutive WAIT cycles; restarts for every issued neuron
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == S_ISSUE) begin
         cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Sticky watchdog flag, cleared only by a new accepted layer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (expire) begin
         err_q <= 1'b1;
      end
   end
`else
   assign hit = n_end_;
   assign res = n_out;
   assign err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (hit) begin
               state_d = (idx_q == LAST) ? S_DONE : S_ISSUE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Latch layer inputs, step the neuron index and collect results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         outs_q   <= '0;
         inputs_q <= '0;
      end else if (accept) begin
         idx_q    <= '0;
         outs_q   <= '0;
         inputs_q <= inputs;
      end else if (state_q == S_WAIT && hit) begin
         outs_q[idx_q] <= res;
         if (idx_q != LAST) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign n_start_ = (state_q == S_ISSUE);
   assign end_     = (state_q == S_DONE);
   assign n_sel    = idx_q;
   assign n_inputs = inputs_q;
   assign outs     = outs_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: directed layers against a timeline model.
// Covers both builds of NEURON_SEQ_TIMEOUT_EN.
module tb_neuron_layer_sequencer;

   localparam int N  = 4;
   localparam int NI = 9;
   localparam int IW = 9;
   localparam int TO = 8;
   localparam int K  = 3;
   localparam int VW = NI * IW;
`ifdef NEURON_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_ = 1'b0;
   logic [VW-1:0] inputs = '0;
   logic          busy, end_, err, n_start_;
   logic [N-1:0]  outs;
   logic [1:0]    n_sel;
   logic [VW-1:0] n_inputs;
   logic          n_out = 1'b0;
   logic          n_end_ = 1'b0;

   neuron_layer_sequencer #(
      .NUM_NEURONS(N), .NUM_INPUTS(NI), .IN_W(IW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_(start_), .inputs(inputs),
      .busy(busy), .end_(end_), .outs(outs), .err(err),
      .n_start_(n_start_), .n_sel(n_sel), .n_inputs(n_inputs),
      .n_out(n_out), .n_end_(n_end_)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;

   task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] pat(int base);
      logic [VW-1:0] v = '0;
      for (int i = 0; i < NI; i++) v[i*IW +: IW] = IW'(base + i);
      return v;
   endfunction

   // Neuron stand-in: answers K cycles after n_start_ with n_sel[0]
   int   stall_sel = -1;
   int   resp_cyc = -1;
   logic resp_val = 1'b0;

   always @(negedge clk) begin
      if (rst_n && n_start_) begin
         if (int'(n_sel) == stall_sel) resp_cyc = -1;
         else begin
            resp_cyc = cyc + K;
            resp_val = n_sel[0];
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         n_end_ = (cyc == resp_cyc);
         n_out  = (cyc == resp_cyc) ? resp_val : 1'b0;
      end
   end

   // Layer model: per-neuron cost table, timeline from prefix sums
   bit            have = 1'b0;
   int            t0 = 0;
   int            cost [N];
   bit            resb [N];
   logic [VW-1:0] m_in = '0;
   int            m_stall = -1;

   function automatic int issue_at(int i);
      int s = 1;
      for (int j = 0; j < i; j++) s += cost[j];
      return s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have = 1'b0;
      end else if (start_ &&
                   !(have && (cyc - t0) <= issue_at(N))) begin
         have = 1'b1;
         t0 = cyc;
         m_in = inputs;
         m_stall = stall_sel;
         for (int i = 0; i < N; i++) begin
            if (i == stall_sel) begin
               cost[i] = TO_EN ? TO + 1 : 1000000;
               resb[i] = 1'b0;
            end else begin
               cost[i] = K + 1;
               resb[i] = i[0];
            end
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      int rel, dn, es;
      logic e_busy, e_end, e_nst, e_err, chk_sel;
      logic [N-1:0] e_outs;
      logic [VW-1:0] e_in;
      e_busy = 0; e_end = 0; e_nst = 0; e_err = 0;
      e_outs = '0; e_in = '0; es = 0; chk_sel = 1'b1;
      if (rst_n && have) begin
         rel = cyc - t0;
         dn = issue_at(N);
         e_busy = (rel >= 1) && (rel <= dn);
         e_end = (rel == dn);
         e_in = m_in;
         chk_sel = (rel >= 1) && (rel < dn);
         for (int i = 0; i < N; i++) begin
            if (issue_at(i) == rel) e_nst = 1'b1;
            if (issue_at(i) <= rel) es = i;
            if (rel >= issue_at(i + 1)) e_outs[i] = resb[i];
         end
         if (TO_EN && m_stall >= 0 && m_stall < N)
            e_err = (rel >= issue_at(m_stall + 1));
      end
      chk("m_busy", busy, e_busy);
      chk("m_end", end_, e_end);
      chk("m_nstart", n_start_, e_nst);
      chk("m_outs", outs, e_outs);
      chk("m_err", err, e_err);
      chk("m_ninputs", n_inputs, e_in);
      if (chk_sel) chk("m_nsel", n_sel, es);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < lim);
      chk("idle_bound", busy, 1'b0);
      step();
   endtask

   initial begin
      int c0, ne, ns, nb, nerr;

      // Reset held with start_ asserted
      rst_n = 1'b0;
      start_ = 1'b1;
      inputs = pat(1);
      repeat (3) step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_outs", outs, 4'b0);
      chk("rst_ninputs", n_inputs, 0);
      chk("rst_nstart", n_start_, 1'b0);
      start_ = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("post_rst_busy", busy, 1'b0);

      // Normal layer with ignored restarts at 6 and 17
      c0 = cyc;
      start_ = 1'b1;
      inputs = pat(1);
      step();
      for (int c = 1; c <= 17; c++) begin
         start_ = (c == 6 || c == 17);
         if (c == 6) inputs = pat(20);
         @(negedge clk);
         chk("l_busy", busy, 1'b1);
         chk("l_nstart", n_start_, (c == 1 || c == 5 || c == 9 || c == 13));
         if (c == 1 || c == 5 || c == 9 || c == 13)
            chk("l_nsel", n_sel, (c - 1) / 4);
         chk("l_end", end_, (c == 17));
         if (c == 17) begin
            chk("l_outs", outs, 4'b1010);
            chk("l_ninputs", n_inputs, pat(1));
         end
         step();
      end
      chk("l_cycle", cyc - c0, 18);
      start_ = 1'b1;
      inputs = pat(40);
      @(negedge clk);
      chk("l18_busy", busy, 1'b0);
      chk("l18_outs", outs, 4'b1010);
      step();
      start_ = 1'b0;
      @(negedge clk);
      chk("l19_nstart", n_start_, 1'b1);
      chk("l19_ninputs", n_inputs, pat(40));
      chk("l19_outs", outs, 4'b0);
      wait_idle(100);

      // Reset in the middle of a layer
      c0 = cyc;
      start_ = 1'b1;
      inputs = pat(7);
      step();
      start_ = 1'b0;
      while (cyc - c0 < 7) step();
      chk("mid_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 1'b0);
      chk("mid_nstart", n_start_, 1'b0);
      chk("mid_outs", outs, 4'b0);
      chk("mid_nsel", n_sel, 2'd0);
      repeat (2) step();
      rst_n = 1'b1;
      ne = 0;
      ns = 0;
      repeat (30) begin
         @(negedge clk);
         if (end_) ne++;
         if (n_start_) ns++;
      end
      chk("mid_no_end", ne, 0);
      chk("mid_no_nstart", ns, 0);
      step();

      // Neuron 2 never answers
      stall_sel = 2;
      c0 = cyc;
      start_ = 1'b1;
      inputs = pat(3);
      step();
      start_ = 1'b0;
`ifdef NEURON_SEQ_TIMEOUT_EN
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         chk("to_err", err, (c >= 18));
         chk("to_nstart", n_start_, (c == 1 || c == 5 || c == 9 || c == 18));
         chk("to_end", end_, (c == 22));
         if (c == 18) chk("to_nsel", n_sel, 2'd3);
         if (c == 22) chk("to_outs", outs, 4'b1010);
         step();
      end
      wait_idle(50);
      stall_sel = -1;
      start_ = 1'b1;
      step();
      start_ = 1'b0;
      @(negedge clk);
      chk("to_err_clear", err, 1'b0);
      wait_idle(100);
`else
      ne = 0;
      nb = 0;
      nerr = 0;
      repeat (200) begin
         @(negedge clk);
         if (end_) ne++;
         if (!busy) nb++;
         if (err) nerr++;
      end
      chk("stall_end", ne, 0);
      chk("stall_busy_low", nb, 0);
      chk("stall_err", nerr, 0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      stall_sel = -1;
      step();
      chk("stall_recover", busy, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/neuron_layer_sequencer.md
# neuron_layer_sequencer

Controller that time-multiplexes one shared `Neuron` datapath across `NUM_NEURONS` neurons of a layer. On a layer start it latches the input vector and walks neuron indices 0..`NUM_NEURONS`-1. For each index it selects the weight set, pulses the neuron start, waits for the neuron end and stores the 1-bit result. It sits between the layer-level control and the single `Neuron` instance.

## Interface
- `NUM_NEURONS`, default 8: neurons in the layer, ≥2.
- `NUM_INPUTS`, default 9: inputs per neuron.
- `IN_W`, default 9: bits per input.
- `TIMEOUT`, default 64: watchdog limit in WAIT cycles. Used only with `NEURON_SEQ_TIMEOUT_EN`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_`  in  1  layer start; active-high, single-cycle pulse.
- `inputs`  in  `NUM_INPUTS*IN_W`  layer input vector; sampled on an accepted `start_`.
- `busy`  out  1  high while a layer is in progress.
- `end_`  out  1  one-cycle layer-done pulse.
- `outs`  out  `NUM_NEURONS`  result vector; bit i is neuron i.
- `err`  out  1  sticky timeout flag.
- `n_start_`  out  1  one-cycle start pulse to the `Neuron`.
- `n_sel`  out  `$clog2(NUM_NEURONS)`  weight-set index for the `Neuron`.
- `n_inputs`  out  `NUM_INPUTS*IN_W`  latched inputs to the `Neuron`.
- `n_out`  in  1  `Neuron` result.
- `n_end_`  in  1  `Neuron` done pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `busy`=0.
  - When `start_`=1: latch `inputs`→`n_inputs`, idx←0, `outs`←0, `err`←0; go to ISSUE.
- **ISSUE**
  - `n_start_`=1 for exactly this cycle; `n_sel`=idx.
  - Always go to WAIT.
- **WAIT**
  - On `n_end_`=1: `outs[idx]`←`n_out`.
  - If idx=`NUM_NEURONS`-1, go to DONE; otherwise idx←idx+1 and go to ISSUE.
- **DONE**
  - `end_`=1 for this one cycle.
  - Go to IDLE.
- `start_` outside IDLE is ignored; this includes the DONE cycle.
- `n_end_` outside WAIT is ignored. The neuron must respond at least 1 cycle after `n_start_`.
- `n_sel` and `n_inputs` stay stable from ISSUE through the end of that neuron's WAIT.
- `outs` holds its value from DONE until the next accepted `start_`.
- `busy` is high in ISSUE, WAIT and DONE.
- `n_start_`, `end_` and `busy` are decoded from the registered state; there is no combinational path from inputs to them.
- `rst_n` low at any time, including mid-layer:
  - Immediately: state=IDLE, idx=0.
  - All outputs 0: `outs`, `n_inputs`, `n_sel`, `n_start_`, `end_`, `busy`, `err`.
  - No `end_` is produced for the aborted layer.

## Timing
- Reference: `start_` is sampled at edge 0, and cycle numbering starts at that edge.
- Neuron latency: the neuron answers k cycles after the `n_start_` cycle, with k ≥ 1.
- Per-neuron cost: k+1 cycles.
- ISSUE for neuron i occurs in cycle 1+i(k+1).
- DONE (`end_`=1) occurs in cycle N(k+1)+1.
- `busy`=1 in cycles 1..N(k+1)+1.
- The earliest next accepted `start_` is in cycle N(k+1)+2.
- All outputs reset to 0.

## Configuration
- `NEURON_SEQ_TIMEOUT_EN`, defined:
  - A WAIT-cycle counter clears on entering WAIT.
  - If the `TIMEOUT`-th consecutive WAIT cycle passes without `n_end_`, treat it as `n_end_` with `n_out`=0 and set `err`=1.
  - `err` is sticky until the next accepted `start_`.
  - The layer still completes and asserts `end_`.
- `NEURON_SEQ_TIMEOUT_EN`, undefined:
  - No counter; WAIT waits indefinitely for `n_end_`.
  - `err` is tied to 0.

## Test plan
1. **Reset:** hold `rst_n`=0 with `start_`=1 → all outputs 0. Release `rst_n` with `start_`=0 → state stays IDLE and `busy`=0.
2. **Normal layer:** N=4; model neuron with k=3 and `n_out`=`n_sel[0]`; `start_` at cycle 0, `inputs` pattern 1..9.
   - `n_start_` in cycles 1, 5, 9, 13 with `n_sel` 0..3.
   - `end_` in cycle 17 only; `busy` high in cycles 1..17.
   - `outs`=4'b1010; `n_inputs` equals the latched pattern.
3. **Ignored restart:** second `start_` in cycles 6 and 17 (`inputs` changed) → only one `end_`, `n_inputs` unchanged. A `start_` in cycle 18 is accepted, with `n_start_` in cycle 19.
4. **Reset mid-op:** `rst_n`=0 in cycle 7 → `busy`, `n_start_`, `outs` and `n_sel` drop to 0 at once. After release, no `end_` and no `n_start_` appear until a new `start_`.
5. **Timeout, macro defined:** `TIMEOUT`=8, N=4, k=3; neuron never answers for `n_sel`=2.
   - WAIT for neuron 2 spans cycles 10..17.
   - `err`=1 from cycle 18; ISSUE for neuron 3 in cycle 18.
   - `end_` in cycle 22; `outs[2]`=0.
   - The next accepted `start_` clears `err`.
6. **Same stall, macro undefined:** `busy` stays 1 and `end_` is never asserted for 200 cycles; `err`=0 throughout.
